// File: rtl/pipe_skid_reg.sv
// Two-entry skid register between pipeline stages with fully registered outputs.
// Ports: clk, reset (async, active-high), flush; in_valid/in_ready/in_data upstream;
//   out_valid/out_ready/out_data downstream; occupancy (0..2); stall_cnt (saturating).
module pipe_skid_reg #(
  parameter int                 DATA_W = 96,
  parameter logic [DATA_W-1:0]  BUBBLE = '0,
  parameter int                 CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] main_nx;
  logic [DATA_W-1:0] skid_nx;
  logic              acc;
  logic              xfer;
  logic              stall;

  assign acc      = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;
  assign stall    = out_valid && !out_ready;
  assign out_data = main_q;

  always_comb begin
    state_nx = state;
    main_nx  = main_q;
    skid_nx  = skid_q;
    if (flush) begin
      state_nx = EMPTY;
      main_nx  = BUBBLE;
      skid_nx  = BUBBLE;
    end else begin
      unique case (state)
        EMPTY: begin
          if (acc) begin
            state_nx = ONE;
            main_nx  = in_data;
          end
        end
        ONE: begin
          unique case ({acc, xfer})
            2'b11: main_nx = in_data;
            2'b10: begin
              state_nx = FULL;
              skid_nx  = in_data;
            end
            2'b01: begin
              state_nx = EMPTY;
              main_nx  = BUBBLE;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (xfer) begin
            state_nx = ONE;
            main_nx  = skid_q;
            skid_nx  = BUBBLE;
          end
        end
        default: begin
          state_nx = EMPTY;
          main_nx  = BUBBLE;
          skid_nx  = BUBBLE;
        end
      endcase
    end
  end

  // Handshake and status flags are registered from the next state so
  // nothing downstream sees a combinational path through this block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      main_q    <= BUBBLE;
      skid_q    <= BUBBLE;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      occupancy <= 2'd0;
    end else begin
      state     <= state_nx;
      main_q    <= main_nx;
      skid_q    <= skid_nx;
      out_valid <= (state_nx != EMPTY);
      in_ready  <= (state_nx != FULL);
      occupancy <= (state_nx == FULL) ? 2'd2 :
                   (state_nx == ONE)  ? 2'd1 : 2'd0;
    end
  end

  // Counts back-pressure cycles; survives flush, only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: accepted inputs are queued,
// a negedge monitor pops and compares on every output handshake.
module tb_pipe_skid_reg;

  localparam int          DW  = 32;
  localparam int          CW  = 4;
  localparam logic [31:0] BUB = 32'hB0B0_B0B0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q[$];

  always #5 clk = ~clk;

  pipe_skid_reg #(
    .DATA_W(DW),
    .BUBBLE(BUB),
    .CNT_W (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: apply inputs just after posedge, then wait to negedge.
  // An input accepted at the coming edge is pushed to the scoreboard.
  task automatic step(input logic iv, input logic [DW-1:0] d,
                      input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    if (fl) q.delete();
    else if (iv && in_ready && !reset) q.push_back(d);
  endtask

  always @(negedge clk) begin
    if (!reset && !flush) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("unexpected_out", {32'd0, out_data}, 64'd0 - 1);
        else check("sb_data", {32'd0, out_data}, {32'd0, q.pop_front()});
      end
      if (!out_valid) check("bubble", {32'd0, out_data}, {32'd0, BUB});
      check("ready_vs_occ", {63'd0, in_ready}, {63'd0, occupancy != 2'd2});
      check("occ_max", {63'd0, occupancy <= 2'd2}, 64'd1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_data", {32'd0, out_data}, {32'd0, BUB});
    check("rst_ready", {63'd0, in_ready}, 64'd1);
    check("rst_occ", {62'd0, occupancy}, 64'd0);
    check("rst_stall", {60'd0, stall_cnt}, 64'd0);
    reset = 1'b0;

    // Stream 1..4 with downstream always ready.
    step(1'b1, 32'd1, 1'b1, 1'b0);
    check("stream_lat", {63'd0, out_valid}, 64'd0);
    for (int i = 2; i <= 5; i++) begin
      step(i <= 4, DW'(i), 1'b1, 1'b0);
      check("stream_data", {32'd0, out_data}, 64'(i - 1));
      check("stream_occ", {62'd0, occupancy}, 64'd1);
      check("stream_rdy", {63'd0, in_ready}, 64'd1);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    check("stream_empty", {62'd0, occupancy}, 64'd0);

    // Back-pressure with A, B.
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    check("bp_a_first", {32'd0, out_data}, 64'hA);
    step(1'b0, '0, 1'b0, 1'b0);
    check("bp_occ2", {62'd0, occupancy}, 64'd2);
    check("bp_rdy0", {63'd0, in_ready}, 64'd0);
    check("bp_a_held", {32'd0, out_data}, 64'hA);
    step(1'b0, '0, 1'b0, 1'b0);
    check("bp_a_stable", {32'd0, out_data}, 64'hA);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("bp_b_out", {32'd0, out_data}, 64'hB);
    check("bp_rdy1", {63'd0, in_ready}, 64'd1);
    check("bp_occ1", {62'd0, occupancy}, 64'd1);
    step(1'b0, '0, 1'b0, 1'b0);
    check("bp_drained", {63'd0, out_valid}, 64'd0);

    // Stall counter saturation, then flush while FULL.
    #3 reset = 1'b1;
    #1 q.delete();
    #2 reset = 1'b0;
    step(1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0);
    for (int k = 3; k <= 22; k++) begin
      step(1'b0, '0, 1'b0, 1'b0);
      if (k == 7) check("stall_5", {60'd0, stall_cnt}, 64'd5);
    end
    check("stall_sat", {60'd0, stall_cnt}, 64'd15);
    check("full_occ", {62'd0, occupancy}, 64'd2);
    step(1'b1, 32'hC, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    check("fl_valid", {63'd0, out_valid}, 64'd0);
    check("fl_data", {32'd0, out_data}, {32'd0, BUB});
    check("fl_occ", {62'd0, occupancy}, 64'd0);
    check("fl_rdy", {63'd0, in_ready}, 64'd1);
    check("fl_stall", {60'd0, stall_cnt}, 64'd15);

    // Flush in ONE with an accepted-looking input: D must vanish.
    step(1'b1, 32'h33, 1'b0, 1'b0);
    step(1'b1, 32'hD, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("fl1_empty", {63'd0, out_valid}, 64'd0);

    // Async reset between edges while FULL.
    step(1'b1, 32'hE, 1'b0, 1'b0);
    step(1'b1, 32'hF, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("ar_full", {62'd0, occupancy}, 64'd2);
    #1 reset = 1'b1;
    #1;
    check("ar_valid", {63'd0, out_valid}, 64'd0);
    check("ar_data", {32'd0, out_data}, {32'd0, BUB});
    check("ar_rdy", {63'd0, in_ready}, 64'd1);
    check("ar_occ", {62'd0, occupancy}, 64'd0);
    check("ar_stall", {60'd0, stall_cnt}, 64'd0);
    q.delete();
    #1 reset = 1'b0;
    step(1'b1, 32'h77, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("ar_first", {32'd0, out_data}, 64'h77);

    // Random 50% traffic; the monitor checks order and occupancy.
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(1)), 32'h1000 + DW'(i),
           1'($urandom_range(1)), 1'b0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("rand_drained", 64'(q.size()), 64'd0);
    check("rand_occ0", {62'd0, occupancy}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
